// File: rtl/sp_ram_be_clr.sv
// Single-port RAM with per-byte write enables and a self-clearing sequence after reset.
// Supports read-first or write-first write-port reads and an optional output register.
module sp_ram_be_clr #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned READ_MODE = 0,
    parameter int unsigned OUT_REG   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    output logic [DATA_W-1:0]   q,
    output logic                q_valid,
    output logic                busy
);

    localparam int unsigned DEPTH  = 2**ADDR_W;
    localparam int unsigned NBYTES = DATA_W/8;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [ADDR_W-1:0]   w_next_clr_addr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rd;

    logic [DATA_W-1:0]   r_q0;
    logic                r_v0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_next_state;
            r_clr_addr <= w_next_clr_addr;
        end
    end

    always_comb begin
        w_old = r_mem[addr];
        for (int unsigned i = 0; i < NBYTES; i++) begin
            w_merged[8*i +: 8] = be[i] ? data[8*i +: 8] : w_old[8*i +: 8];
        end
        w_rd = (READ_MODE == 1 && we) ? w_merged : w_old;
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_clr_addr = r_clr_addr;
        w_accept        = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_addr      = addr;
        w_mem_wdata     = w_merged;
        busy            = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                busy            = 1'b1;
                // Suppress the zeroing write while reset holds the pointer at 0.
                w_mem_we        = !rst;
                w_mem_addr      = r_clr_addr;
                w_mem_wdata     = '0;
                w_next_clr_addr = r_clr_addr + 1'b1;
                if (&r_clr_addr) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_accept = req;
                w_mem_we = req && we;
            end
            default: w_next_state = ST_CLEAR;
        endcase
    end

    // Memory has no reset; contents are zeroed only by the clear walk.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q0 <= '0;
            r_v0 <= 1'b0;
        end else begin
            r_v0 <= w_accept;
            if (w_accept) begin
                r_q0 <= w_rd;
            end
        end
    end

    generate
        if (OUT_REG == 1) begin : g_out_reg
            logic [DATA_W-1:0] r_q1;
            logic              r_v1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q1 <= '0;
                    r_v1 <= 1'b0;
                end else begin
                    r_v1 <= r_v0;
                    if (r_v0) begin
                        r_q1 <= r_q0;
                    end
                end
            end

            assign q       = r_q1;
            assign q_valid = r_v1;
        end else begin : g_no_out_reg
            assign q       = r_q0;
            assign q_valid = r_v0;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_be_clr.sv
// Drives four parameter variants of sp_ram_be_clr with shared random stimulus and
// compares each against a word-level model of the memory, clear timing and output latency.
module tb_sp_ram_be_clr;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  be;
    logic [5:0]  addr;
    logic [15:0] data;

    // a: read-first, b: write-first, c: read-first + out reg, d: write-first + out reg
    logic [15:0] q_a, q_b, q_c, q_d;
    logic        v_a, v_b, v_c, v_d;
    logic        b_a, b_b, b_c, b_d;

    int unsigned n_checks;
    int unsigned n_fail;

    // Model state
    logic [15:0] m_mem [64];
    int          m_clr_left;
    logic [15:0] m_q0 [2];
    logic        m_v0;
    logic [15:0] m_q1 [2];
    logic        m_v1;

    sp_ram_be_clr #(.DATA_W(16), .ADDR_W(6), .READ_MODE(0), .OUT_REG(0)) u_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .data(data),
        .q(q_a), .q_valid(v_a), .busy(b_a));
    sp_ram_be_clr #(.DATA_W(16), .ADDR_W(6), .READ_MODE(1), .OUT_REG(0)) u_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .data(data),
        .q(q_b), .q_valid(v_b), .busy(b_b));
    sp_ram_be_clr #(.DATA_W(16), .ADDR_W(6), .READ_MODE(0), .OUT_REG(1)) u_c (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .data(data),
        .q(q_c), .q_valid(v_c), .busy(b_c));
    sp_ram_be_clr #(.DATA_W(16), .ADDR_W(6), .READ_MODE(1), .OUT_REG(1)) u_d (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .data(data),
        .q(q_d), .q_valid(v_d), .busy(b_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic exp_busy;
        exp_busy = (m_clr_left > 0);
        chk("busy_a", 64'(b_a), 64'(exp_busy));
        chk("busy_b", 64'(b_b), 64'(exp_busy));
        chk("busy_c", 64'(b_c), 64'(exp_busy));
        chk("busy_d", 64'(b_d), 64'(exp_busy));
        chk("q_a", 64'(q_a), 64'(m_q0[0]));
        chk("q_b", 64'(q_b), 64'(m_q0[1]));
        chk("q_c", 64'(q_c), 64'(m_q1[0]));
        chk("q_d", 64'(q_d), 64'(m_q1[1]));
        chk("v_a", 64'(v_a), 64'(m_v0));
        chk("v_b", 64'(v_b), 64'(m_v0));
        chk("v_c", 64'(v_c), 64'(m_v1));
        chk("v_d", 64'(v_d), 64'(m_v1));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 16'h0000;
        m_clr_left = 64;
        m_q0[0] = '0; m_q0[1] = '0;
        m_q1[0] = '0; m_q1[1] = '0;
        m_v0 = 1'b0;
        m_v1 = 1'b0;
    endtask

    // One clock edge: update the model from the inputs seen at the edge, then check.
    task automatic step();
        logic [15:0] old_w, new_w, mask;
        @(posedge clk);
        if (!rst) begin
            if (m_v0) begin
                m_q1[0] = m_q0[0];
                m_q1[1] = m_q0[1];
            end
            m_v1 = m_v0;
            if (m_clr_left > 0) begin
                m_clr_left--;
                m_v0 = 1'b0;
            end else if (req) begin
                old_w = m_mem[addr];
                mask  = {{8{be[1]}}, {8{be[0]}}};
                new_w = (old_w & ~mask) | (data & mask);
                if (we) m_mem[addr] = new_w;
                m_q0[0] = old_w;
                m_q0[1] = we ? new_w : old_w;
                m_v0 = 1'b1;
            end else begin
                m_v0 = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] b,
                         input logic [5:0] a, input logic [15:0] d);
        req = r; we = w; be = b; addr = a; data = d;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000);
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic rand_cycle(input int unsigned addr_hi);
        drive(($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom),
              6'($urandom_range(0, addr_hi)), 16'($urandom));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; data = '0;
        model_reset();
        #1;
        check_all();
        repeat (3) step();
        rst = 1'b0;

        // Clear sequence with write attempts that must be ignored.
        for (int i = 0; i < 64; i++) begin
            if (i == 10 || i == 40) drive(1'b1, 1'b1, 2'b11, 6'd5, 16'h5555);
            else rand_cycle(63);
        end
        chk("clear_done_busy", 64'(b_a), 64'(0));

        drive(1'b1, 1'b0, 2'b00, 6'd63, 16'h0000);
        chk("clr_rd63_q", 64'(q_a), 64'h0000);
        chk("clr_rd63_v", 64'(v_a), 64'(1));
        drive(1'b1, 1'b0, 2'b00, 6'd5, 16'h0000);
        chk("busy_wr_ignored", 64'(q_a), 64'h0000);

        drive(1'b1, 1'b1, 2'b11, 6'd1, 16'hA55A);
        drive(1'b1, 1'b1, 2'b10, 6'd1, 16'hFF00);
        drive(1'b1, 1'b0, 2'b00, 6'd1, 16'h0000);
        chk("be_merge", 64'(q_a), 64'hFF5A);

        drive(1'b1, 1'b1, 2'b11, 6'd2, 16'h1234);
        drive(1'b1, 1'b1, 2'b11, 6'd2, 16'hBEEF);
        chk("read_first", 64'(q_a), 64'h1234);
        chk("write_first", 64'(q_b), 64'hBEEF);

        drive(1'b1, 1'b1, 2'b00, 6'd2, 16'h0000);
        chk("be0_valid", 64'(v_a), 64'(1));
        chk("be0_nochange", 64'(q_b), 64'hBEEF);

        drive(1'b1, 1'b1, 2'b11, 6'd0, 16'h00C3);
        idle();
        drive(1'b1, 1'b0, 2'b00, 6'd0, 16'h0000);
        chk("lat_e1_v", 64'(v_c), 64'(0));
        idle();
        chk("lat_e2_q", 64'(q_c), 64'h00C3);
        chk("lat_e2_v", 64'(v_c), 64'(1));
        idle();
        chk("lat_e3_v", 64'(v_c), 64'(0));

        for (int i = 0; i < 400; i++) rand_cycle(15);
        for (int i = 0; i < 200; i++) rand_cycle(63);

        // Reset in the middle of an access burst, then in the middle of a clear.
        assert_rst();
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) rand_cycle(63);
        assert_rst();
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) rand_cycle(63);
        chk("midclr_busy_end", 64'(b_d), 64'(0));

        for (int i = 0; i < 300; i++) rand_cycle(7);
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 2'b00, 6'(i % 64), 16'h0000);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_ram_be_clr.md
SP_RAM_BE_CLR -- requirements
Module: sp_ram_be_clr

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, data width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL provide parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter READ_MODE, default 0, write-port read behaviour; 0 = read-first (old data), 1 = write-first (new merged data).
REQ-004 SHALL provide parameter OUT_REG, default 0; 1 adds one output pipeline register.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port req, input, 1 bit: access request, sampled on rising clk.
REQ-008 SHALL have port we, input, 1 bit: 1 = write, 0 = read; valid only with req.
REQ-009 SHALL have port be, input, DATA_W/8 bits: byte enables; be[i] governs data[8i+7:8i].
REQ-010 SHALL have port addr, input, ADDR_W bits: word address.
REQ-011 SHALL have port data, input, DATA_W bits: write data.
REQ-012 SHALL have port q, output, DATA_W bits: read data.
REQ-013 SHALL have port q_valid, output, 1 bit: one-cycle pulse marking q as updated for an accepted request.
REQ-014 SHALL have port busy, output, 1 bit: high while the clear sequence runs; requests are ignored while it is high.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and IDLE, with a clear pointer clr_addr of ADDR_W bits.
REQ-016 SHALL, in CLEAR, write all-zero to mem[clr_addr] each cycle and increment clr_addr.
REQ-017 SHALL move from CLEAR to IDLE on the edge that writes clr_addr = DEPTH-1, so a full clear takes DEPTH cycles.
REQ-018 SHALL drive busy = 1 in CLEAR and busy = 0 in IDLE.
REQ-019 SHALL, while busy, perform no user write, leave q unchanged and hold q_valid = 0 regardless of req, we and be.
REQ-020 SHALL accept a request in IDLE when req = 1 on a rising edge.
REQ-021 SHALL, for an accepted read (we = 0), load q with mem[addr] on the same edge; with OUT_REG=1, q is loaded one edge later.
REQ-022 SHALL, for an accepted write (we = 1), update only the bytes with be[i] = 1 and leave all other bytes unchanged.
REQ-023 SHALL, on an accepted write, load q with the pre-write word when READ_MODE=0, or the post-merge word when READ_MODE=1.
REQ-024 SHALL treat a write with be = 0 as a no-op on memory that still updates q and pulses q_valid.
REQ-025 SHALL assert q_valid for exactly one cycle per accepted request, aligned with the q update (latency 1 + OUT_REG cycles).
REQ-026 SHALL, with back-to-back requests, sustain one access per cycle and keep q_valid high continuously.
REQ-027 SHALL make q hold its last value whenever no request is accepted.
REQ-028 SHALL, when OUT_REG=1, also delay q_valid through the pipeline register so that it stays aligned with q.

Reset
REQ-029 SHALL, while rst is high, force state = CLEAR, clr_addr = 0, q = 0, q_valid = 0, busy = 1 (and the OUT_REG stage = 0), independent of clk.
REQ-030 SHALL not reset memory contents asynchronously; contents are zeroed only by the clear sequence.
REQ-031 SHALL, on rst assertion mid-clear or mid-access, abandon the operation and restart the clear from address 0 after release.
REQ-032 SHALL begin clearing at mem[0] on the first rising edge after rst deasserts.

Verification
REQ-033 SHALL pass the clear check: after reset release, busy stays high for exactly 64 cycles, then a read of addr 63 returns q = 16'h0000 with a q_valid pulse.
REQ-034 SHALL pass the byte-enable check: write 16'hA55A with be = 2'b11 to addr 1, then 16'hFF00 with be = 2'b10 -> a read of addr 1 gives q = 16'hFF5A.
REQ-035 SHALL pass the read-mode check: with mem[2] = 16'h1234, write 16'hBEEF to addr 2 -> q = 16'h1234 when READ_MODE=0, or 16'hBEEF when READ_MODE=1.
REQ-036 SHALL pass the latency check: with OUT_REG=1, a read of addr 0 after writing 16'h00C3 gives q = 16'h00C3 two edges after the request, and q_valid high for exactly that one cycle.
REQ-037 SHALL pass the busy check: req with we = 1, data 16'h5555, addr 5 issued during the clear -> no q_valid, and mem[5] reads 16'h0000 afterwards.
REQ-038 SHALL pass the mid-clear reset check: rst pulsed at clear cycle 30 -> busy stays high for 64 cycles after release, and q = 0 throughout.
